sha_req_queue: RTL and testbench
================================

# sha_req_queue

Request queue directly upstream of the SHA control FSM. Host bytes are assembled into full SHA instructions of 3·ADDRW+2 bits and held in a circular FIFO. The head entry is presented to the FSM on a valid/ready handshake and dequeued when the FSM accepts it. The queue decouples host command rate from SHA operation latency.

## Interface
- ADDRW, 24: address width; instruction width IW = 3·ADDRW+2.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- NBYTES, ceil(IW/8): host bytes per instruction (10 at default).
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte, little-endian within instruction.
- in_ready  out  1  queue accepts in_data this cycle.
- flush  in  1  synchronous clear of FIFO and assembler.
- req_valid  out  1  head entry present.
- req_data  out  IW  head instruction.
- req_ready  in  1  FSM dequeue (the FSM's ready_req_out).

## Operation
- Instruction fields: [IW-1:IW-2] opcode; [3·ADDRW-1:2·ADDRW] key address; [2·ADDRW-1:ADDRW] text address; [ADDRW-1:0] destination address.
- Assembler: byte counter 0..NBYTES-1. Byte k is written to bits [8k+7:8k]. Bits ≥IW of the last byte are discarded.
- Byte accept = in_valid && in_ready. On accept at count NBYTES-1, the assembled word plus the last byte is pushed, and the counter wraps to 0.
- in_ready = 1 when count ≠ NBYTES-1, else !full. in_ready never depends combinationally on req_ready.
- Pop = req_valid && req_ready. rd_ptr advances by one.
- Push and pop in the same cycle:
  - Legal when not full.
  - When full, in_ready on the last byte is 0, so a push cannot occur.
  - Occupancy is unchanged when both happen.
- Pointers: log2(DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index equal and wrap bits differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- req_valid = !empty. req_data = mem[rd_ptr index], stable while req_valid is high and no pop occurs.
- flush (wins over everything):
  - Next cycle: pointers 0, counter 0, partial word discarded.
  - Push and pop in the flush cycle are ignored.
  - in_ready is still driven normally during flush, but the byte is dropped.

## Timing
- Reset values: req_valid 0, in_ready 1, req_data 0 (storage is not reset, but the output mux reads 0 while empty), counter 0, pointers 0.
- Latency:
  - Last byte accepted in cycle N with queue empty → req_valid=1 in cycle N+1.
  - Pop in cycle N → the next entry (or req_valid=0) appears in cycle N+1.
- Throughput: one instruction per NBYTES cycles in; one pop per cycle out.
- Full: the counter stalls at NBYTES-1 with the partial word held. Earlier bytes continue to be accepted.
- Reset mid-assembly or with occupancy: everything is discarded, identical to flush.

## Configuration
- SHA_REQQ_COUNT_EN defined:
  - Adds output count [log2(DEPTH):0] = wr_ptr − rd_ptr (occupancy 0..DEPTH), registered, reset 0, cleared by flush.
  - Adds sticky output ovf_err, set when in_valid is high on the last byte while full. Cleared only by reset or flush.
- Not defined: neither port exists. Behaviour is otherwise identical.

## Structure
- Shared package sha_pkg:
  - Field offset localparams (OPC_LSB, KEY_LSB, TXT_LSB, DST_LSB).
  - Opcode constants.
  - ACCEL_ID and MEM_ID, reused by the SHA FSM.
- Sub-module sha_req_assembler: byte counter plus shift/insert register. Outputs word and word_valid. Takes a stall input (full) and flush.
- Top level holds the FIFO storage, the pointers, and the optional count/ovf logic.

## Test plan
- Reset, then 10 bytes 0x01..0x0A with continuous in_valid → req_valid rises the cycle after byte 0x0A. req_data[71:0] = 0x0908_0706_0504_0302_01 with the upper 2 bits = 0x0A & 2'b11.
- Push 4 instructions with req_ready=0 → full. A fifth instruction's bytes 0..8 are accepted, then in_ready=0 at byte 9. Pop one → in_ready=1 next cycle, and the fifth instruction completes.
- Continuous streaming with req_ready=1 → entries are popped in push order, with no loss across 3 full pointer wraps (≥24 instructions).
- Assert flush after byte 5 of an instruction with 2 entries queued → next cycle req_valid=0 and count=0. The following 10 bytes form a clean new instruction.
- Synchronous reset with 3 entries queued → req_valid=0 and in_ready=1 the next cycle. The first instruction after reset is unaffected by stale partial bytes.
- With SHA_REQQ_COUNT_EN defined, in_valid held high while full on byte 9 → ovf_err=1 and sticky, count=4. After flush, ovf_err=0.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA definitions: instruction field offsets, opcodes and bus IDs
// used by the request queue and the SHA control FSM.
package sha_pkg;

  localparam int SHA_ADDRW = 24;
  localparam int SHA_IW    = 3 * SHA_ADDRW + 2;

  localparam int DST_LSB = 0;
  localparam int TXT_LSB = SHA_ADDRW;
  localparam int KEY_LSB = 2 * SHA_ADDRW;
  localparam int OPC_LSB = 3 * SHA_ADDRW;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_UPDATE = 2'd1,
    OP_FINAL  = 2'd2,
    OP_DIGEST = 2'd3
  } opcode_e;

  localparam logic [7:0] ACCEL_ID = 8'h5A;
  localparam logic [7:0] MEM_ID   = 8'hA5;

  // Host bytes needed to carry one instruction of iw bits.
  function automatic int nbytes_of(input int iw);
    return (iw + 7) / 8;
  endfunction

endpackage

// File: rtl/sha_req_assembler.sv
// Assembles little-endian host bytes into one IW-bit instruction; the last
// byte is merged combinationally so the word is pushed in its accept cycle.
module sha_req_assembler #(
  parameter int IW     = 74,
  parameter int NBYTES = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          stall,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          word_valid,
  output logic [IW-1:0] word
);

  localparam int CW = $clog2(NBYTES);
  localparam int LB = IW - 8 * (NBYTES - 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [CW-1:0] cnt_reg;
  logic [7:0]    byte_reg [NBYTES-1];
  logic          at_last;
  logic          accept;

  assign at_last    = (cnt_reg == LAST);
  assign in_ready   = !at_last || !stall;
  assign accept     = in_valid && in_ready;
  assign word_valid = accept && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= at_last ? '0 : cnt_reg + CW'(1);
    end
  end

  // Stale bytes need no clearing: the counter restarts at 0 and every slot
  // is rewritten before the next word can complete.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NBYTES - 1; k++) begin
      if (accept && cnt_reg == CW'(k)) begin
        byte_reg[k] <= in_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES - 1; gi++) begin : g_byte
      assign word[8*gi +: 8] = byte_reg[gi];
    end
  endgenerate

  assign word[IW-1 -: LB] = in_data[LB-1:0];

endmodule

// File: rtl/sha_req_queue.sv
// Byte-fed circular request FIFO in front of the SHA control FSM.
// Optional feature macro SHA_REQQ_COUNT_EN adds count and ovf_err outputs.
module sha_req_queue #(
  parameter int ADDRW  = 24,
  parameter int DEPTH  = 4,
  parameter int NBYTES = sha_pkg::nbytes_of(3 * ADDRW + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 req_valid,
  output logic [3*ADDRW+1:0]   req_data,
  input  logic                 req_ready
`ifdef SHA_REQQ_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf_err
`endif
);

  import sha_pkg::*;

  localparam int IW = 3 * ADDRW + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic          empty, full;
  logic          word_valid;
  logic [IW-1:0] word;
  logic          push, pop;

  sha_req_assembler #(
    .IW     (IW),
    .NBYTES (NBYTES)
  ) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .stall      (full),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .word_valid (word_valid),
    .word       (word)
  );

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // The assembler cannot complete a word while full, so push needs no
  // separate full check.
  assign push = word_valid && !flush;
  assign pop  = req_valid && req_ready && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (!rst_n || flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_reg <= wr_ptr_next;
    rd_ptr_reg <= rd_ptr_next;
  end

  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem[wr_ptr_reg[AW-1:0]] <= word;
    end
  end

  assign req_valid = !empty;
  assign req_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

`ifdef SHA_REQQ_COUNT_EN
  // in_ready only drops on the last byte while full, so a refused valid
  // byte is exactly the overflow condition.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      count <= wr_ptr_next - rd_ptr_next;
      if (in_valid && !in_ready) ovf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sha_req_queue.sv
// Directed, table-driven bench for sha_req_queue (default ADDRW/DEPTH).
module tb_sha_req_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        req_valid;
  logic [73:0] req_data;
  logic        req_ready;
`ifdef SHA_REQQ_COUNT_EN
  logic [2:0]  count;
  logic        ovf_err;
`endif

  always #5 clk = ~clk;

  sha_req_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready)
`ifdef SHA_REQQ_COUNT_EN
    ,
    .count     (count),
    .ovf_err   (ovf_err)
`endif
  );

  typedef struct {
    logic [79:0] bytes;
    logic [73:0] exp;
  } vec_t;

  vec_t        tbl [5];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_en = 1'b0;
  logic [73:0] exp_q [$];
  int          n_popped = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_byte_timeout: in_ready stuck at 0, required 1");
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [79:0] b);
    for (int k = 0; k < 10; k++) send_byte(b[8*k +: 8]);
  endtask

  task automatic pop_one;
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  function automatic logic [79:0] stream_bytes(input int i);
    logic [7:0] top;
    top = 8'hFC | 8'(i & 3);
    return {top, 24'(i * 7 + 3), 24'(i ^ 24'h5A5A5A), 24'(~i)};
  endfunction

  // Checks every pop against the scoreboard during the streaming test.
  always @(negedge clk) begin
    if (mon_en && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        check("stream_unexpected_pop", 80'(req_valid), 80'(1'b0));
      end else begin
        check("stream_data", 80'(req_data), 80'(exp_q[0]));
        $display("stream pop %0d data %h", n_popped, req_data);
        void'(exp_q.pop_front());
        n_popped++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; req_ready = 1'b0;

    tbl[0] = '{80'hFD_112233_445566_778899, 74'h1_112233_445566_778899};
    tbl[1] = '{80'h02_AAAAAA_555555_000000, 74'h2_AAAAAA_555555_000000};
    tbl[2] = '{80'hFF_FFFFFF_FFFFFF_FFFFFF, 74'h3_FFFFFF_FFFFFF_FFFFFF};
    tbl[3] = '{80'h04_000001_800000_C0FFEE, 74'h0_000001_800000_C0FFEE};
    tbl[4] = '{80'h7E_DEADBE_EF0123_456789, 74'h2_DEADBE_EF0123_456789};

    // Reset state
    step(); step();
    rst_n = 1'b1;
    check("reset_req_valid", 80'(req_valid), 80'(1'b0));
    check("reset_in_ready", 80'(in_ready), 80'(1'b1));
    check("reset_req_data", 80'(req_data), 80'h0);
`ifdef SHA_REQQ_COUNT_EN
    check("reset_count", 80'(count), 80'(0));
    check("reset_ovf", 80'(ovf_err), 80'(0));
`endif

    // Bytes 0x01..0x0A, req_valid the cycle after the last byte
    for (int k = 1; k <= 9; k++) send_byte(8'(k));
    check("basic_valid_before_last", 80'(req_valid), 80'(1'b0));
    send_byte(8'h0A);
    $display("basic instr data %h", req_data);
    check("basic_valid_after_last", 80'(req_valid), 80'(1'b1));
    check("basic_data", 80'(req_data), 80'({2'b10, 72'h09_0807_0605_0403_0201}));
    pop_one();
    check("basic_empty_after_pop", 80'(req_valid), 80'(1'b0));

    // Table vectors: fill to full, stall fifth instruction on its last byte
    for (int i = 0; i < 4; i++) begin
      send_instr(tbl[i].bytes);
      $display("push table %0d", i);
    end
    check("full_valid", 80'(req_valid), 80'(1'b1));
    check("full_head", 80'(req_data), 80'(tbl[0].exp));
    check("full_key_field", 80'(req_data[sha_pkg::KEY_LSB +: 24]), 80'(24'h112233));
    for (int k = 0; k < 9; k++) send_byte(tbl[4].bytes[8*k +: 8]);
    in_valid = 1'b1;
    in_data  = tbl[4].bytes[79:72];
    check("full_stall_in_ready", 80'(in_ready), 80'(1'b0));
    step(); step();
    check("full_stall_held", 80'(in_ready), 80'(1'b0));
    check("full_head_stable", 80'(req_data), 80'(tbl[0].exp));
`ifdef SHA_REQQ_COUNT_EN
    check("full_count", 80'(count), 80'(4));
    check("ovf_set", 80'(ovf_err), 80'(1'b1));
    step();
    check("ovf_sticky", 80'(ovf_err), 80'(1'b1));
`endif
    pop_one();
    check("unstall_in_ready", 80'(in_ready), 80'(1'b1));
    check("unstall_head", 80'(req_data), 80'(tbl[1].exp));
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check("drain_valid", 80'(req_valid), 80'(1'b1));
      check("drain_data", 80'(req_data), 80'(tbl[i].exp));
      $display("pop table %0d data %h", i, req_data);
      pop_one();
    end
    check("drain_empty", 80'(req_valid), 80'(1'b0));
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef SHA_REQQ_COUNT_EN
    check("ovf_cleared_by_flush", 80'(ovf_err), 80'(1'b0));
`endif

    // Streaming with continuous pops across several pointer wraps
    req_ready = 1'b1;
    mon_en    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [79:0] b;
      b = stream_bytes(i);
      exp_q.push_back({b[73:72], b[71:0]});
      send_instr(b);
    end
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
    step();
    mon_en    = 1'b0;
    req_ready = 1'b0;
    check("stream_all_popped", 80'(n_popped), 80'(24));
    check("stream_empty", 80'(req_valid), 80'(1'b0));

    // Flush mid-assembly with two entries queued; byte offered during flush is dropped
    send_instr(tbl[0].bytes);
    send_instr(tbl[1].bytes);
    for (int k = 0; k < 5; k++) send_byte(tbl[2].bytes[8*k +: 8]);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_req_valid", 80'(req_valid), 80'(1'b0));
    check("flush_in_ready", 80'(in_ready), 80'(1'b1));
    check("flush_req_data", 80'(req_data), 80'h0);
`ifdef SHA_REQQ_COUNT_EN
    check("flush_count", 80'(count), 80'(0));
`endif
    send_instr(tbl[3].bytes);
    check("post_flush_valid", 80'(req_valid), 80'(1'b1));
    check("post_flush_data", 80'(req_data), 80'(tbl[3].exp));
    pop_one();
    check("post_flush_empty", 80'(req_valid), 80'(1'b0));

    // Synchronous reset with three entries queued and a partial word
    for (int i = 0; i < 3; i++) send_instr(tbl[i].bytes);
    for (int k = 0; k < 3; k++) send_byte(tbl[4].bytes[8*k +: 8]);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_req_valid", 80'(req_valid), 80'(1'b0));
    check("rst_in_ready", 80'(in_ready), 80'(1'b1));
    check("rst_req_data", 80'(req_data), 80'h0);
    send_instr(tbl[4].bytes);
    check("post_rst_valid", 80'(req_valid), 80'(1'b1));
    check("post_rst_data", 80'(req_data), 80'(tbl[4].exp));
    pop_one();
    check("post_rst_empty", 80'(req_valid), 80'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
